pac_input_ctrl: RTL and testbench

PAC_INPUT_CTRL -- requirements
Module: pac_input_ctrl

---
 rtl/pac_pkg.sv | 27 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/pac_input_ctrl.sv | 119 +++++++++++
 tb/tb_pac_input_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared encodings for the PAC input path and the downstream movement logic.
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam int unsigned NUM_BTNS = 4;

    // Button bit order is {up, down, left, right}; lowest set bit wins.
    function automatic dir_e prio_dir(input logic [NUM_BTNS-1:0] ev);
        if (ev[0])      return DIR_RIGHT;
        else if (ev[1]) return DIR_LEFT;
        else if (ev[2]) return DIR_DOWN;
        else if (ev[3]) return DIR_UP;
        else            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a consecutive-stable-cycle debouncer for
// one active-low push-button; clean is the active-high pressed level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic clean
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_n};
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (~sync_q[1] == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = ~clean_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer resets to released so a held button needs a full debounce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/pac_input_ctrl.sv
// Debounced four-button direction input with priority resolution, a one-deep
// pending direction and tick-based expiry of unconsumed requests.
module pac_input_ctrl
    import pac_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_TICKS      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       direita,
    input  logic       esquerda,
    input  logic       baixo,
    input  logic       cima,
    input  logic       tick,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir,
    output logic [3:0] btn_clean
);

    localparam int unsigned AW = $clog2(HOLD_TICKS) + 1;
    localparam logic [AW-1:0] AGE_LAST = AW'(HOLD_TICKS - 1);

    logic [NUM_BTNS-1:0] raw_n;
    logic [NUM_BTNS-1:0] clean_w;
    logic [NUM_BTNS-1:0] prev_q, prev_d;
    logic [NUM_BTNS-1:0] press_w;
    logic                ev_valid_q, ev_valid_d;
    dir_e                ev_dir_q, ev_dir_d;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    dir_e                dir_q, dir_d;
    logic [AW-1:0]       age_q, age_d;

    assign raw_n = {cima, baixo, esquerda, direita};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn_n (raw_n[i]),
            .clean (clean_w[i])
        );
    end

    // Press events are resolved and registered before they reach the FSM.
    always_comb begin
        prev_d     = clean_w;
        press_w    = clean_w & ~prev_q;
        ev_valid_d = |press_w;
        ev_dir_d   = prio_dir(press_w);
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        age_d   = age_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_valid_q) begin
                    state_d = ST_PENDING;
                    valid_d = 1'b1;
                    dir_d   = ev_dir_q;
                    age_d   = '0;
                end
            end
            ST_PENDING: begin
                if (ev_valid_q) begin
                    dir_d = ev_dir_q;
                    age_d = '0;
                end else if (dir_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (tick) begin
                    if (age_q == AGE_LAST) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        age_d = age_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_dir_q   <= DIR_RIGHT;
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            dir_q      <= DIR_RIGHT;
            age_q      <= '0;
        end else begin
            prev_q     <= prev_d;
            ev_valid_q <= ev_valid_d;
            ev_dir_q   <= ev_dir_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            age_q      <= age_d;
        end
    end

    assign dir_valid = valid_q;
    assign dir       = dir_q;
    assign btn_clean = clean_w;

endmodule

// File: tb/tb_pac_input_ctrl.sv
// Scoreboard bench for pac_input_ctrl: a window-based reference model predicts
// the outputs after every edge and a negedge monitor compares them.
module tb_pac_input_ctrl;
    import pac_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned HT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btns_n = 4'b1111;
    logic       tick = 1'b0;
    logic       dir_ready = 1'b0;
    logic       dir_valid;
    logic [1:0] dir;
    logic [3:0] btn_clean;

    int total = 0;
    int bad = 0;
    int m_consumes = 0;
    int dut_consumes = 0;

    always #5 clk = ~clk;

    pac_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_TICKS     (HT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .direita   (btns_n[0]),
        .esquerda  (btns_n[1]),
        .baixo     (btns_n[2]),
        .cima      (btns_n[3]),
        .tick      (tick),
        .dir_ready (dir_ready),
        .dir_valid (dir_valid),
        .dir       (dir),
        .btn_clean (btn_clean)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic [3:0] c;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] rawq[$];
    logic [3:0] evq[$];
    logic [3:0] m_clean;
    int         m_flip[4];
    int         k;
    logic       m_valid;
    logic [1:0] m_dir;
    int         m_age;

    function automatic bit pressed_at(int b, int e);
        if (e < 0) return 1'b0;
        return rawq[e][b];
    endfunction

    function automatic logic [1:0] pick(logic [3:0] ev);
        for (int b = 0; b < 4; b++) if (ev[b]) return b[1:0];
        return 2'b00;
    endfunction

    // A clean level flips when the last DB synchronized samples (raw delayed
    // by two edges) all disagree with it and none of them predate the last flip.
    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] flips;
        logic [3:0] ev;
        bit         all_diff;
        if (!reset) begin
            rawq.delete();
            evq.delete();
            m_clean = '0;
            m_flip  = '{default: -1};
            k       = 0;
            m_valid = 1'b0;
            m_dir   = 2'b00;
            m_age   = 0;
            e       = '{v: 1'b0, d: 2'b00, c: 4'b0000};
        end else begin
            rawq.push_back(~btns_n);
            flips = '0;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(DB); j++)
                    if (pressed_at(b, k - 2 - j) == m_clean[b]) all_diff = 1'b0;
                if (k - int'(DB) + 1 <= m_flip[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean[b] = ~m_clean[b];
                    m_flip[b]  = k;
                    if (m_clean[b]) flips[b] = 1'b1;
                end
            end
            evq.push_back(flips);
            ev = (k >= 2) ? evq[k-2] : 4'b0000;
            if (m_valid && dir_ready) m_consumes++;
            if (!m_valid) begin
                if (|ev) begin
                    m_valid = 1'b1;
                    m_dir   = pick(ev);
                    m_age   = 0;
                end
            end else if (|ev) begin
                m_dir = pick(ev);
                m_age = 0;
            end else if (dir_ready) begin
                m_valid = 1'b0;
            end else if (tick) begin
                if (m_age == int'(HT) - 1) m_valid = 1'b0;
                else m_age++;
            end
            k++;
            e = '{v: m_valid, d: m_dir, c: m_clean};
        end
        expq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            if (!reset) begin
                check("rst_valid", dir_valid, 0);
                check("rst_dir", dir, 0);
                check("rst_clean", btn_clean, 0);
            end else begin
                check("sb_valid", dir_valid, e.v);
                if (e.v) check("sb_dir", dir, e.d);
                check("sb_clean", btn_clean, e.c);
                if (dir_valid && dir_ready) dut_consumes++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int hold[4];
        int c0;
        cyc(3);
        // Right held from edge 0: valid exactly at edge 7.
        reset = 1'b1;
        btns_n[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 check("lat_pre", dir_valid, 0);
        @(posedge clk);
        #1 check("lat_valid", dir_valid, 1);
        check("lat_dir", dir, DIR_RIGHT);
        check("lat_clean", btn_clean, 4'b0001);
        #1 btns_n[0] = 1'b1;
        cyc(10);
        dir_ready = 1'b1;
        cyc(1);
        dir_ready = 1'b0;
        check("consume_idle", dir_valid, 0);

        // Bouncing up button never settles.
        for (int i = 0; i < 10; i++) begin
            btns_n[3] = ~btns_n[3];
            cyc(2);
            check("bounce_clean", btn_clean[3], 0);
            check("bounce_valid", dir_valid, 0);
        end

        // Left and up together: left wins, no later up.
        btns_n[1] = 1'b0;
        btns_n[3] = 1'b0;
        cyc(8);
        check("simul_valid", dir_valid, 1);
        check("simul_dir", dir, DIR_LEFT);
        dir_ready = 1'b1;
        cyc(1);
        dir_ready = 1'b0;
        cyc(10);
        check("simul_no_up", dir_valid, 0);
        btns_n = 4'b1111;
        cyc(10);

        // Consume coinciding with a down press event.
        btns_n[0] = 1'b0;
        cyc(8);
        check("p34_valid", dir_valid, 1);
        btns_n[2] = 1'b0;
        cyc(7);
        dir_ready = 1'b1;
        cyc(1);
        dir_ready = 1'b0;
        check("p34_still", dir_valid, 1);
        check("p34_dir", dir, DIR_DOWN);
        dir_ready = 1'b1;
        cyc(1);
        dir_ready = 1'b0;
        check("p34_idle", dir_valid, 0);
        btns_n = 4'b1111;
        cyc(10);

        // Expiry after HT ticks, then consume beating expiry.
        for (int pass = 0; pass < 2; pass++) begin
            btns_n[1] = 1'b0;
            cyc(8);
            btns_n[1] = 1'b1;
            for (int t = 0; t < 2; t++) begin
                tick = 1'b1;
                cyc(1);
                tick = 1'b0;
                cyc(2);
            end
            check("age_alive", dir_valid, 1);
            c0 = dut_consumes;
            tick = 1'b1;
            dir_ready = (pass == 1);
            cyc(1);
            tick = 1'b0;
            dir_ready = 1'b0;
            check("age_drop", dir_valid, 0);
            check("age_consume", dut_consumes, c0 + pass);
            cyc(10);
        end

        // Asynchronous reset mid-pending, button held through it.
        btns_n[0] = 1'b0;
        cyc(8);
        check("pre_rst_valid", dir_valid, 1);
        reset = 1'b0;
        #1 check("async_rst", dir_valid, 0);
        cyc(3);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("rst_lat_pre", dir_valid, 0);
        @(posedge clk);
        #1 check("rst_lat_valid", dir_valid, 1);
        #1 btns_n[0] = 1'b1;
        dir_ready = 1'b1;
        cyc(1);
        dir_ready = 1'b0;
        cyc(10);

        // Random phase: mix of bounces and stable holds.
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    btns_n[b] = ~btns_n[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(DB + 2, 20));
                end else begin
                    hold[b]--;
                end
            end
            dir_ready = ($urandom_range(0, 3) == 0);
            tick      = ($urandom_range(0, 4) == 0);
            cyc(1);
        end
        dir_ready = 1'b0;
        tick = 1'b0;
        cyc(3);
        check("consume_total", dut_consumes, m_consumes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
